// File: rtl/pe_cfg_sequencer.sv
// Configuration sequencer feeding the PE functional-unit cluster: replays a
// small program of config words with per-entry repeat counts, passes, stall and abort.
module pe_cfg_sequencer #(
  parameter int CONFIG_ALL = 64,
  parameter int DEPTH      = 16,
  parameter int REP_W      = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [CONFIG_ALL-1:0] prog_cfg,
  input  logic [REP_W-1:0]      prog_rep,
  input  logic [ADDR_W-1:0]     last_idx,
  input  logic [REP_W-1:0]      loop_count,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  abort,
  output logic [CONFIG_ALL-1:0] config_all,
  output logic                  cfg_valid,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [CONFIG_ALL-1:0] mem_cfg [DEPTH];
  logic [REP_W-1:0]      mem_rep [DEPTH];
  logic [ADDR_W-1:0]     pc_q;
  logic [ADDR_W-1:0]     last_q;
  logic [REP_W-1:0]      loops_q;
  logic [REP_W-1:0]      rep_cnt;
  logic [REP_W-1:0]      pass_cnt;
  logic [CONFIG_ALL-1:0] cfg_q;
  logic                  valid_q;
  logic                  done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_cfg  <= '{default: '0};
      mem_rep  <= '{default: '0};
      pc_q     <= '0;
      last_q   <= '0;
      loops_q  <= '0;
      rep_cnt  <= '0;
      pass_cnt <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        if (state == RUN) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          cfg_q   <= '0;
        end
      end else if (!stall) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              last_q   <= last_idx;
              loops_q  <= loop_count;
              pc_q     <= '0;
              rep_cnt  <= '0;
              pass_cnt <= '0;
              cfg_q    <= mem_cfg[0];
              valid_q  <= 1'b1;
              state    <= RUN;
            end else if (prog_we) begin
              mem_cfg[prog_addr] <= prog_cfg;
              mem_rep[prog_addr] <= prog_rep;
            end
          end
          RUN: begin
            if (rep_cnt < mem_rep[pc_q]) begin
              rep_cnt <= rep_cnt + 1'b1;
            end else if (pc_q < last_q) begin
              pc_q    <= pc_q + 1'b1;
              rep_cnt <= '0;
              cfg_q   <= mem_cfg[pc_q + 1'b1];
            end else if (loops_q != '0 && REP_W'(pass_cnt + 1'b1) == loops_q) begin
              // pass_cnt + 1 == loops_q is the same test as pass_cnt == loops_q - 1
              state   <= IDLE;
              valid_q <= 1'b0;
              cfg_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              pc_q    <= '0;
              rep_cnt <= '0;
              cfg_q   <= mem_cfg[0];
              if (loops_q != '0) pass_cnt <= pass_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    cfg_valid  = valid_q & ~stall;
    config_all = cfg_valid ? cfg_q : '0;
    busy       = (state == RUN);
    done       = done_q;
    pc         = pc_q;
  end

endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// Self-checking bench for pe_cfg_sequencer: expected output streams are built
// from the program contents as a flat queue of (index, config) per live cycle.
module tb_pe_cfg_sequencer;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [63:0] prog_cfg;
  logic [7:0]  prog_rep;
  logic [3:0]  last_idx;
  logic [7:0]  loop_count;
  logic        start;
  logic        stall;
  logic        abort;
  logic [63:0] config_all;
  logic        cfg_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  pe_cfg_sequencer #(.CONFIG_ALL(64), .DEPTH(16), .REP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_cfg(prog_cfg), .prog_rep(prog_rep), .last_idx(last_idx),
    .loop_count(loop_count), .start(start), .stall(stall), .abort(abort),
    .config_all(config_all), .cfg_valid(cfg_valid), .pc(pc), .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [63:0] m_cfg [16];
  logic [7:0]  m_rep [16];
  logic [67:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int addr, input logic [63:0] cfg, input logic [7:0] rep);
    prog_we   = 1'b1;
    prog_addr = 4'(addr);
    prog_cfg  = cfg;
    prog_rep  = rep;
    next_cycle();
    prog_we   = 1'b0;
    m_cfg[addr] = cfg;
    m_rep[addr] = rep;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i] = '0;
      m_rep[i] = '0;
    end
  endtask

  // Every live cycle of every pass, in presentation order.
  task automatic build(input int last, input int passes);
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int e = 0; e <= last; e++)
        for (int r = 0; r <= int'(m_rep[e]); r++)
          exp_q.push_back({4'(e), m_cfg[e]});
  endtask

  task automatic run_seq(input int last, input int loops, input int abort_at,
                         input int stall_at, input int stall_len,
                         input bit rnd_stall, input int inject_at);
    int          live;
    int          guard;
    int          stalled;
    bit          stall_now;
    bit          aborted;
    logic [67:0] head;
    build(last, (loops == 0) ? 20 : loops);
    last_idx   = 4'(last);
    loop_count = 8'(loops);
    start      = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", cfg_valid, 0);
    next_cycle();
    start   = 1'b0;
    live    = 0;
    guard   = 0;
    stalled = 0;
    aborted = 1'b0;
    while (exp_q.size() > 0 && guard < 4000 && !aborted) begin
      guard++;
      stall_now = (live == stall_at && stalled < stall_len) ||
                  (rnd_stall && $urandom_range(0, 3) == 0);
      stall = stall_now;
      if (!stall_now && live == inject_at) begin
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_cfg  = ~m_cfg[1];
        prog_rep  = 8'd3;
        start     = 1'b1;
      end
      if (!stall_now && live == abort_at) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clk);
      head = exp_q[0];
      if (stall_now) begin
        chk("stall_cfg", config_all, 0);
        chk("stall_valid", cfg_valid, 0);
        chk("stall_busy", busy, 1);
        chk("stall_pc", pc, head[67:64]);
        stalled++;
      end else begin
        void'(exp_q.pop_front());
        chk("live_cfg", config_all, head[63:0]);
        chk("live_valid", cfg_valid, 1);
        chk("live_busy", busy, 1);
        chk("live_pc", pc, head[67:64]);
        chk("live_done", done, 0);
        live++;
      end
      next_cycle();
      stall   = 1'b0;
      abort   = 1'b0;
      prog_we = 1'b0;
      start   = 1'b0;
    end
    if (!aborted) chk("seq_timeout", exp_q.size(), 0);
    @(negedge clk);
    chk("end_done", done, aborted ? 0 : 1);
    chk("end_busy", busy, 0);
    chk("end_valid", cfg_valid, 0);
    chk("end_cfg", config_all, 0);
    next_cycle();
    @(negedge clk);
    chk("done_pulse", done, 0);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_cfg = '0; prog_rep = '0;
    last_idx = '0; loop_count = '0; start = 1'b0; stall = 1'b0; abort = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg", config_all, 0);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pc, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Three single-cycle entries, one pass
    prog(0, 64'hA, 8'd0);
    prog(1, 64'hB, 8'd0);
    prog(2, 64'hC, 8'd0);
    run_seq(2, 1, -1, -1, 0, 1'b0, -1);

    // Repeat counts over two passes, then again with a 3-cycle stall
    prog(0, 64'h11, 8'd2);
    prog(1, 64'h22, 8'd0);
    run_seq(1, 2, -1, -1, 0, 1'b0, -1);
    run_seq(1, 2, -1, 1, 3, 1'b0, -1);

    // Endless loop cut by abort, then a fresh replay from entry 0
    run_seq(1, 0, 20, -1, 0, 1'b0, -1);
    run_seq(1, 1, -1, -1, 0, 1'b0, -1);

    // Writes and start are ignored while running; writes land once idle
    run_seq(1, 1, -1, -1, 0, 1'b0, 0);
    prog(1, 64'h5555_AAAA_0000_FFFF, 8'd1);
    run_seq(1, 1, -1, -1, 0, 1'b0, -1);

    // Random programs with random stalls
    for (int it = 0; it < 4; it++) begin
      for (int e = 0; e < 16; e++)
        prog(e, {$urandom, $urandom}, 8'($urandom_range(0, 3)));
      run_seq(int'($urandom_range(0, 15)), int'($urandom_range(1, 3)), -1, -1, 0, 1'b1, -1);
    end

    // Asynchronous reset mid-run clears outputs and the program
    last_idx = 4'd2; loop_count = 8'd0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (3) next_cycle();
    chk("pre_rst_valid", cfg_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_cfg", config_all, 0);
    chk("async_valid", cfg_valid, 0);
    chk("async_busy", busy, 0);
    next_cycle();
    rst_n = 1'b1;
    clear_model();
    next_cycle();
    run_seq(0, 1, -1, -1, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_cfg_sequencer.md
Name: pe_cfg_sequencer

Overview:
Configuration sequencer that sits directly upstream of the PE functional-unit cluster and drives its 64-bit config_all word every cycle.
- Holds a small program of configuration entries, each with a per-entry repeat count.
- Steps through the entries for a programmed number of passes, with stall and abort control.
- Outputs an all-zero NOP configuration whenever idle or stalled.

Parameters:
- CONFIG_ALL, 64, width of one configuration word; matches the FU cluster config_all.
- DEPTH, 16, number of program entries; must be a power of two.
- REP_W, 8, width of the per-entry repeat count and of the pass count.
- ADDR_W (localparam), $clog2(DEPTH), entry index width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- prog_we  input  1  program write strobe
- prog_addr  input  ADDR_W  entry index to write
- prog_cfg  input  CONFIG_ALL  configuration word to store
- prog_rep  input  REP_W  extra cycles to hold this entry (0 = one cycle)
- last_idx  input  ADDR_W  index of the final entry of a pass; sampled on start
- loop_count  input  REP_W  number of passes; 0 = run until abort; sampled on start
- start  input  1  begin sequence (honoured in IDLE only)
- stall  input  1  freeze sequencer and mask output
- abort  input  1  return to IDLE
- config_all  output  CONFIG_ALL  configuration word to the FU cluster
- cfg_valid  output  1  config_all carries a live entry
- pc  output  ADDR_W  index of the entry currently presented
- busy  output  1  state is RUN
- done  output  1  one-cycle pulse when the final pass completes

Behaviour:
- Reset (async, rst_n low):
  - state IDLE.
  - All memory entries and repeat counts cleared to 0.
  - pc, rep_cnt, pass_cnt, cfg_q and valid_q cleared to 0.
  - done = 0, busy = 0, config_all = 0, cfg_valid = 0; outputs go to 0 immediately.
- Storage: DEPTH × (CONFIG_ALL + REP_W) flop array.
  - prog_we is honoured only in IDLE with start low; ignored otherwise (no error flag).
- Output masking (combinational):
  - config_all = (valid_q & ~stall) ? cfg_q : 0.
  - cfg_valid = valid_q & ~stall.
  - busy = (state == RUN).
- Priority at each edge: abort > stall > start/sequencing > prog_we.
- IDLE:
  - On start: latch last_idx and loop_count; pc←0; rep_cnt←0; pass_cnt←0; cfg_q←mem[0]; valid_q←1; go to RUN.
  - Latency: start sampled at edge N → mem[0] visible from cycle N+1.
  - start while already in RUN is ignored.
- RUN, per edge with stall=0:
  - rep_cnt < rep[pc]: rep_cnt++; hold entry.
  - else if pc < last_idx: pc++; rep_cnt←0; cfg_q←mem[pc+1].
  - else (end of pass):
    - If loop_count≠0 and pass_cnt == loop_count−1: go to IDLE; valid_q←0; cfg_q←0; done←1 for one cycle.
    - Otherwise: pc←0; rep_cnt←0; cfg_q←mem[0]; pass_cnt++ (not incremented when loop_count=0).
- Stall: all state and counters frozen; output masked to 0. Sequencing resumes at the identical entry and rep_cnt when stall drops; the stalled cycle does not count toward repeats.
- Abort: next edge goes to IDLE, valid_q←0, cfg_q←0, and done is not asserted. Abort in IDLE is a no-op.
- done is registered; high exactly in the first cycle after the last live entry, which is also the first idle cycle.
- last_idx = 0 gives a single-entry program. Reset mid-run discards the program, so the program must be rewritten.

Test Plan:
1. Program entries 0..2 = 0xA, 0xB, 0xC with rep 0; last_idx=2; loop_count=1; start at edge N → config_all = A, B, C in cycles N+1..N+3; 0 in cycle N+4; done=1 only in N+4; busy=1 in N+1..N+3; pc = 0, 1, 2.
2. Entry0 = 0x11 with rep 2, entry1 = 0x22 with rep 0; last_idx=1; loop_count=2 → sequence 11, 11, 11, 22, 11, 11, 11, 22, then 0 with a single done pulse.
3. In test 2, stall high for 3 cycles during the second 0x11 → config_all = 0 and cfg_valid = 0 for those cycles; then the remaining sequence continues with two more 0x11 then 22; the total live-cycle count is unchanged.
4. loop_count=0 with 2 entries; run 20 cycles; assert abort → IDLE next cycle, config_all = 0, done never asserted; a new start replays from entry 0.
5. During RUN, prog_we to entry 1 with a new value and a start pulse → both ignored; the old value still appears. After returning to IDLE the write succeeds.
6. Pull rst_n low mid-run → config_all, cfg_valid and busy go to 0 immediately. After release, start with last_idx=0 → config_all = 0 (memory cleared) with cfg_valid = 1 for one cycle, then done.
